axi_read_ctrl: RTL and testbench

//  AXI4 read-channel slave that converts AR bursts into single-beat L2/lint memory reads and returns R beats.

---
 rtl/axi2lint_pkg.sv | 21 ++
 rtl/axi_read_resp_fifo.sv | 49 ++++
 rtl/axi_read_ctrl.sv | 177 +++++++++++++++++
 tb/tb_axi_read_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2lint_pkg.sv
// Shared encodings for the axi_2_lint bridge: AXI response/burst codes and read FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi2lint_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'b00,
        RD_BURST = 2'b01,
        RD_ERR   = 2'b10
    } rd_state_e;

endpackage

// File: rtl/axi_read_resp_fifo.sv
// Response FIFO holding packed R beats; head is read straight from the storage flops.
// Latency: a push is visible at the head one cycle later (no fall-through).
// Backpressure: caller must never push when full; occupancy exported on count.
module axi_read_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage, pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= wdata;
                wr_ptr        <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem_q[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/axi_read_ctrl.sv
// AXI4 read slave: splits AR bursts into single-beat lint reads and returns them as R beats.
// Latency: AR handshake at T, first memory request granted at T+1, first R beat presented after T+2.
// Backpressure: requests are only issued with a free FIFO slot reserved, so RREADY stalls throttle the memory side.
module axi_read_ctrl
    import axi2lint_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_RDATA_WIDTH   = 64,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10,
    parameter int MEM_ADDR_WIDTH     = 13,
    parameter int FIFO_DEPTH         = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI4_ID_WIDTH-1:0]      ARID_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i,
    input  logic [7:0]                    ARLEN_i,
    input  logic [2:0]                    ARSIZE_i,
    input  logic [1:0]                    ARBURST_i,
    input  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i,
    input  logic                          ARVALID_i,
    output logic                          ARREADY_o,
    output logic [AXI4_ID_WIDTH-1:0]      RID_o,
    output logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o,
    output logic [1:0]                    RRESP_o,
    output logic                          RLAST_o,
    output logic [AXI4_USER_WIDTH-1:0]    RUSER_o,
    output logic                          RVALID_o,
    input  logic                          RREADY_i,
    output logic                          MEM_CEN_o,
    output logic                          MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
    output logic [AXI4_RDATA_WIDTH/8-1:0] MEM_BE_o,
    output logic                          MEM_size_o,
    input  logic [AXI4_RDATA_WIDTH-1:0]   MEM_Q_i,
    output logic                          valid_o,
    input  logic                          grant_i
);

    localparam int NUMBYTES = AXI4_RDATA_WIDTH / 8;
    localparam int OFF      = $clog2(NUMBYTES);
    localparam int FW       = AXI4_RDATA_WIDTH + AXI4_ID_WIDTH + AXI4_USER_WIDTH + 3;
    localparam int CW       = $clog2(FIFO_DEPTH + 1);

    rd_state_e cs, ns;

    logic [AXI4_ID_WIDTH-1:0]   id_q;
    logic [AXI4_USER_WIDTH-1:0] user_q;
    logic [MEM_ADDR_WIDTH-1:0]  addr_q;
    logic [7:0]                 len_q;
    logic [2:0]                 size_q;
    logic [1:0]                 burst_q;
    logic [8:0]                 beat_q;

    logic [AXI4_ID_WIDTH-1:0]   meta_id;
    logic [AXI4_USER_WIDTH-1:0] meta_user;
    logic                       meta_last;
    logic                       inflight;

    logic          ar_rdy, mem_req, err_push, grant, last_beat, credit, push, pop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          fifo_empty;
    logic [FW-1:0] fifo_wdata, fifo_rdata;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^ARADDR_i[AXI4_ADDRESS_WIDTH-1:MEM_ADDR_WIDTH];

    assign last_beat = (beat_q == {1'b0, len_q});
    assign grant     = mem_req & grant_i;
    assign pop       = RVALID_o & RREADY_i;
    assign push      = inflight | err_push;

    // Slots already claimed: stored beats plus the one returning from memory, minus the one leaving now.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign credit    = occupancy < (CW+1)'(FIFO_DEPTH);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs <= RD_IDLE;
        else        cs <= ns;
    end

    // Next state and per-state strobes; unsupported bursts are answered with SLVERR beats.
    always_comb begin
        ns       = cs;
        ar_rdy   = 1'b0;
        mem_req  = 1'b0;
        err_push = 1'b0;
        case (cs)
            RD_IDLE: begin
                ar_rdy = 1'b1;
                if (ARVALID_i)
                    ns = (ARBURST_i == BURST_INCR || ARBURST_i == BURST_FIXED) ? RD_BURST : RD_ERR;
            end
            RD_BURST: begin
                mem_req = credit;
                if (credit && grant_i && last_beat) ns = RD_IDLE;
            end
            RD_ERR: begin
                err_push = credit;
                if (credit && last_beat) ns = RD_IDLE;
            end
            default: ns = RD_IDLE;
        endcase
    end

    // Capture the AR command and advance the beat counter as each beat is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= '0;
            user_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else if (ar_rdy && ARVALID_i) begin
            id_q    <= ARID_i;
            user_q  <= ARUSER_i;
            addr_q  <= ARADDR_i[MEM_ADDR_WIDTH-1:0];
            len_q   <= ARLEN_i;
            size_q  <= ARSIZE_i;
            burst_q <= ARBURST_i;
            beat_q  <= '0;
        end else if (grant || err_push) begin
            beat_q  <= beat_q + 9'd1;
        end
    end

    // Sideband for the beat currently returning from memory (data arrives one cycle after grant).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= 1'b0;
            meta_id   <= '0;
            meta_user <= '0;
            meta_last <= 1'b0;
        end else begin
            inflight <= grant;
            if (grant) begin
                meta_id   <= id_q;
                meta_user <= user_q;
                meta_last <= last_beat;
            end
        end
    end

    // Memory beats and error beats never coincide: an error burst starts at least two cycles after the last grant.
    assign fifo_wdata = inflight ? {MEM_Q_i, meta_id, meta_user, RESP_OKAY, meta_last}
                                 : {{AXI4_RDATA_WIDTH{1'b0}}, id_q, user_q, RESP_SLVERR, last_beat};

    axi_read_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {RDATA_o, RID_o, RUSER_o, RRESP_o, RLAST_o} = fifo_rdata;
    assign RVALID_o   = ~fifo_empty;
    assign ARREADY_o  = ar_rdy;
    assign valid_o    = mem_req;
    assign MEM_CEN_o  = ~mem_req;
    assign MEM_WEN_o  = 1'b1;
    assign MEM_BE_o   = '1;
    assign MEM_size_o = (size_q == 3'b011);
    assign MEM_A_o    = (burst_q == BURST_INCR) ? addr_q + (MEM_ADDR_WIDTH'(beat_q) << OFF) : addr_q;

endmodule

// File: tb/tb_axi_read_ctrl.sv
// Directed bench for axi_read_ctrl with a lint-memory model, address and R-beat scoreboards.
// Latency: checks the T+3 first-beat timing and back-to-back issue.
// Backpressure: exercises RREADY stalls, grant stalls and reset during a burst.
module tb_axi_read_ctrl;
    import axi2lint_pkg::*;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [63:0] data;
        logic [15:0] id;
        logic [9:0]  user;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ARID_i;
    logic [31:0] ARADDR_i;
    logic [7:0]  ARLEN_i;
    logic [2:0]  ARSIZE_i;
    logic [1:0]  ARBURST_i;
    logic [9:0]  ARUSER_i;
    logic        ARVALID_i, ARREADY_o;
    logic [15:0] RID_o;
    logic [63:0] RDATA_o;
    logic [1:0]  RRESP_o;
    logic        RLAST_o;
    logic [9:0]  RUSER_o;
    logic        RVALID_o, RREADY_i;
    logic        MEM_CEN_o, MEM_WEN_o, MEM_size_o;
    logic [12:0] MEM_A_o;
    logic [7:0]  MEM_BE_o;
    logic [63:0] MEM_Q_i = '0;
    logic        valid_o;
    logic        grant_i = 1'b1;

    always #5 clk = ~clk;

    axi_read_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ARID_i(ARID_i), .ARADDR_i(ARADDR_i), .ARLEN_i(ARLEN_i), .ARSIZE_i(ARSIZE_i),
        .ARBURST_i(ARBURST_i), .ARUSER_i(ARUSER_i), .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
        .RID_o(RID_o), .RDATA_o(RDATA_o), .RRESP_o(RRESP_o), .RLAST_o(RLAST_o), .RUSER_o(RUSER_o),
        .RVALID_o(RVALID_o), .RREADY_i(RREADY_i),
        .MEM_CEN_o(MEM_CEN_o), .MEM_WEN_o(MEM_WEN_o), .MEM_A_o(MEM_A_o), .MEM_BE_o(MEM_BE_o),
        .MEM_size_o(MEM_size_o), .MEM_Q_i(MEM_Q_i), .valid_o(valid_o), .grant_i(grant_i)
    );

    rbeat_t      exp_r_q[$];
    logic [12:0] exp_a_q[$];
    int          gcyc[$];
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0;
    int          g_cnt = 0, p_cnt = 0, max_out = 0, cen_low = 0;
    logic        pend_vld = 1'b0;
    logic [12:0] pend_a = '0;
    logic        gnt_toggle = 1'b0;

    function automatic logic [63:0] memfn(input logic [12:0] a);
        return {16'hBEEF, 3'b000, a, 16'hC0DE, 3'b000, ~a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model and grant driver: data for a grant at edge N is applied just after edge N.
    always @(posedge clk) begin
        #1;
        if (pend_vld) MEM_Q_i = memfn(pend_a);
        grant_i = gnt_toggle ? ~grant_i : 1'b1;
    end

    // Monitor: everything sampled here takes effect at the following rising edge.
    always @(negedge clk) begin
        rbeat_t act;
        pend_vld = rst_n && valid_o && grant_i;
        pend_a   = MEM_A_o;
        if (!MEM_CEN_o) cen_low++;
        if (pend_vld) begin
            g_cnt++;
            gcyc.push_back(cyc);
            if (exp_a_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL mem_addr: unexpected request at %h, expected none", MEM_A_o);
            end else chk("mem_addr", 128'(MEM_A_o), 128'(exp_a_q.pop_front()));
        end
        if (rst_n && RVALID_o && RREADY_i) begin
            p_cnt++;
            act = {RDATA_o, RID_o, RUSER_o, RRESP_o, RLAST_o};
            if (exp_r_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL r_beat: unexpected beat %h, expected none", act);
            end else chk("r_beat", 128'(act), 128'(exp_r_q.pop_front()));
        end
        if (g_cnt - p_cnt > max_out) max_out = g_cnt - p_cnt;
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [9:0] user);
        int k;
        for (int i = 0; i <= int'(len); i++) begin
            logic [12:0] a;
            rbeat_t      b;
            a = addr[12:0];
            if (burst == BURST_INCR) a = a + 13'(i * 8);
            b.id   = id;
            b.user = user;
            b.last = (i == int'(len));
            if (burst == BURST_INCR || burst == BURST_FIXED) begin
                exp_a_q.push_back(a);
                b.data = memfn(a);
                b.resp = RESP_OKAY;
            end else begin
                b.data = '0;
                b.resp = RESP_SLVERR;
            end
            exp_r_q.push_back(b);
        end
        ARID_i = id; ARADDR_i = addr; ARLEN_i = len; ARBURST_i = burst; ARUSER_i = user;
        ARSIZE_i = 3'b011; ARVALID_i = 1'b1;
        k = 0;
        while (!ARREADY_o && k < 500) begin step(1); k++; end
        if (!ARREADY_o) begin
            n_cmp++; n_err++;
            $display("FAIL ar_handshake: ARREADY_o stayed 0 for %0d cycles, required 1", k);
        end
        step(1);
        ARVALID_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_r_q.size() != 0 || exp_a_q.size() != 0) && k < 2000) begin step(1); k++; end
        n_cmp++;
        if (exp_r_q.size() != 0 || exp_a_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_%s: %0d beats / %0d requests outstanding, required 0", name,
                     exp_r_q.size(), exp_a_q.size());
        end
        step(2);
        chk({"rvalid_idle_", name}, 128'(RVALID_o), 128'(0));
    endtask

    task automatic chk_span(input string name, input int n, input int span);
        chk({name, "_grants"}, 128'(gcyc.size()), 128'(n));
        if (gcyc.size() == n) chk({name, "_span"}, 128'(gcyc[n-1] - gcyc[0]), 128'(span));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; ARVALID_i = 1'b0; ARID_i = '0; ARADDR_i = '0; ARLEN_i = '0;
        ARSIZE_i = 3'b011; ARBURST_i = '0; ARUSER_i = '0; RREADY_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_arready", 128'(ARREADY_o), 128'(1));
        chk("rst_rvalid",  128'(RVALID_o),  128'(0));
        chk("rst_valid",   128'(valid_o),   128'(0));
        chk("rst_cen",     128'(MEM_CEN_o), 128'(1));
        chk("rst_wen",     128'(MEM_WEN_o), 128'(1));
        chk("rst_be",      128'(MEM_BE_o),  128'(8'hFF));
        chk("rst_rpayload", 128'({RDATA_o, RID_o, RUSER_o, RRESP_o, RLAST_o}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2);

        // Single beat and first-beat latency.
        issue(16'h1234, 32'h100, 8'd0, BURST_INCR, 10'h155);
        k = 0;
        while (!RVALID_o && k < 20) begin @(negedge clk); k++; end
        chk("first_rvalid_latency", 128'(k), 128'(3));
        @(posedge clk); #1;
        drain("single");

        // INCR len3 back-to-back.
        gcyc.delete();
        issue(16'h0042, 32'h100, 8'd3, BURST_INCR, 10'h2A);
        chk("mem_size", 128'(MEM_size_o), 128'(1));
        drain("incr4");
        chk_span("incr4", 4, 3);

        // RREADY stall mid-burst.
        g_cnt = 0; p_cnt = 0; max_out = 0;
        issue(16'h00A3, 32'h200, 8'd7, BURST_INCR, 10'h0F0);
        step(1);
        RREADY_i = 1'b0;
        step(10);
        chk("stall_no_request", 128'(valid_o), 128'(0));
        RREADY_i = 1'b1;
        drain("stall");
        chk("stall_max_outstanding", 128'(max_out), 128'(DEPTH));

        // Grant toggling on an 8-beat INCR.
        gcyc.delete();
        gnt_toggle = 1'b1;
        issue(16'h0B0B, 32'h300, 8'd7, BURST_INCR, 10'h3FF);
        drain("toggle");
        gnt_toggle = 1'b0;
        chk_span("toggle", 8, 14);

        // Unsupported WRAP burst.
        step(1);
        cen_low = 0;
        issue(16'h0055, 32'h500, 8'd1, BURST_WRAP, 10'h001);
        drain("wrap_err");
        chk("err_no_mem_access", 128'(cen_low), 128'(0));

        // FIXED burst repeats one address.
        gcyc.delete();
        issue(16'h0F1C, 32'h400, 8'd2, BURST_FIXED, 10'h123);
        drain("fixed");
        chk_span("fixed", 3, 2);

        // Address wrap at 2^13, upper AR bits ignored.
        issue(16'h0777, 32'h8000_1FF8, 8'd1, BURST_INCR, 10'h200);
        drain("addr_wrap");

        // 256-beat burst.
        gcyc.delete();
        issue(16'h0ABC, 32'h0, 8'd255, BURST_INCR, 10'h0AA);
        drain("len256");
        chk_span("len256", 256, 255);

        // Reset during a stalled burst drops everything.
        RREADY_i = 1'b0;
        issue(16'h0999, 32'h600, 8'd7, BURST_INCR, 10'h099);
        step(4);
        chk("pre_reset_rvalid", 128'(RVALID_o), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("reset_rvalid_async", 128'(RVALID_o), 128'(0));
        chk("reset_valid_async",  128'(valid_o),  128'(0));
        chk("reset_arready",      128'(ARREADY_o), 128'(1));
        exp_r_q.delete();
        exp_a_q.delete();
        step(2);
        rst_n = 1'b1;
        RREADY_i = 1'b1;
        step(10);
        chk("post_reset_rvalid", 128'(RVALID_o), 128'(0));
        issue(16'h0321, 32'h700, 8'd0, BURST_INCR, 10'h321);
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
